vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 single-bit vga_sync block. It generates VGA timing counters, sync pulses, blanking and a once-per-frame tick, for any mode and sync polarity. It drives multi-bit colour, with sync and blank delayed to match a configurable pixel-pipeline latency. It sits between game/render logic (snake_head and successors) and the VGA pins, and runs from a fast clock throttled by a pixel-enable.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
COLOR_W, 4, bits per colour channel
LAT, 1, render latency in pixel ticks from counter out to colour in (0..3)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
pix_en  in  1  pixel tick qualifier; all state advances only when high
h_count  out  CW  current pixel column, CW = clog2(H_TOTAL)
v_count  out  CW_V  current line, CW_V = clog2(V_TOTAL)
active  out  1  h_count < H_ACTIVE and v_count < V_ACTIVE (undelayed)
frame_tick  out  1  one-clock pulse at the last pixel of a frame
red, green, blue  in  COLOR_W each  colour from render logic, LAT ticks after h/v
red_out, green_out, blue_out  out  COLOR_W each  gated colour to DAC
horiz_sync_out  out  1  hsync at pin, aligned with colour
vert_sync_out  out  1  vsync at pin, aligned with colour

Behaviour:
- H_TOTAL = sum of the H_* parameters (800 by default); V_TOTAL = sum of the V_* parameters (525 by default).
- Reset, asynchronous, to:
  - h_count = 0, v_count = 0, active = 1, frame_tick = 0;
  - colour outputs = 0;
  - sync outputs = inactive level (~HS_POL, ~VS_POL);
  - delay-pipeline contents = blank and inactive.
- On a clock with pix_en = 1:
  - h_count increments; at H_TOTAL-1 it wraps to 0 and v_count increments;
  - v_count wraps from V_TOTAL-1 to 0.
- On a clock with pix_en = 0: every register holds, including the pipelines and the colour output registers; frame_tick = 0.
- Raw sync, from the counters:
  - hs_raw is asserted while h_count is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1];
  - vs_raw is asserted while v_count is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (entire lines).
- frame_tick = pix_en AND h_count = H_TOTAL-1 AND v_count = V_TOTAL-1. It is combinational on the registered counters, high for exactly one clock per frame.
- Alignment pipeline: {active, hs_raw, vs_raw} pass through LAT pix_en-qualified stages, then one output register stage.
  - Colour inputs are registered in the same output stage: out = delayed_active ? colour : 0.
  - Pin latency from counter value to pins = LAT+1 pixel ticks, for sync and colour alike.
  - LAT = 0: no delay stages, output register only.
- Sync polarity is applied at the output register (out = asserted XNOR POL).
- Reset mid-frame: restart at (0,0) on the next pix_en after release. No partial frame_tick is emitted; pipeline contents are discarded.
- Widths: counters are unsigned. Compares use full-width constants, with no truncation for modes up to 2048x2048 total.

Decomposition:
- Shared package vga_pkg holds:
  - mode localparams for 640x480@60 (default) and 800x600@72;
  - polarity constants;
  - the function computing counter width.
- One natural sub-module, vga_delay_line (WIDTH, DEPTH, pix_en-qualified shift register). It is used for the {active, hs, vs} alignment.

Test Plan:
1. Reset asserted mid-line, then released with pix_en = 1 → all outputs at reset values while reset is held; h_count = 0 on the first clock after release, then counting 0, 1, 2 ...
2. Defaults, pix_en = 1, LAT = 1 → horiz_sync_out low for exactly 96 clocks per 800-clock line, first low clock 658 clocks after h_count = 0 (656 + LAT+1); vert_sync_out low for 2 full lines per 525.
3. frame_tick counting over 3 frames → pulses exactly 420000 clocks apart, each 1 clock wide, coinciding with h_count = 799, v_count = 524.
4. pix_en toggling 1/0 every clock → line period of 1600 clocks; all outputs frozen on pix_en = 0 clocks; frame_tick never high when pix_en = 0.
5. red = 4'hF constant, LAT = 2 → red_out = F exactly for pixel ticks 3..642 of each visible line, 0 elsewhere and on lines 480..524.
6. HS_POL = 1, VS_POL = 1, mode 800x600@72 → hsync high for 120 ticks per 1040-tick line; vsync high for 6 lines per 666; reset value of both syncs is 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: standard display modes, sync polarities and
// the counter-width helper used to size the pixel and line counters.
package vga_pkg;

    localparam bit POL_ACTIVE_LOW  = 1'b0;
    localparam bit POL_ACTIVE_HIGH = 1'b1;

    // 640x480 @ 60 Hz, 25.175 MHz pixel rate, both syncs negative
    localparam int M640_H_ACTIVE = 640;
    localparam int M640_H_FP     = 16;
    localparam int M640_H_SYNC   = 96;
    localparam int M640_H_BP     = 48;
    localparam int M640_V_ACTIVE = 480;
    localparam int M640_V_FP     = 10;
    localparam int M640_V_SYNC   = 2;
    localparam int M640_V_BP     = 33;
    localparam bit M640_HS_POL   = POL_ACTIVE_LOW;
    localparam bit M640_VS_POL   = POL_ACTIVE_LOW;

    // 800x600 @ 72 Hz, 50 MHz pixel rate, both syncs positive
    localparam int M800_H_ACTIVE = 800;
    localparam int M800_H_FP     = 56;
    localparam int M800_H_SYNC   = 120;
    localparam int M800_H_BP     = 64;
    localparam int M800_V_ACTIVE = 600;
    localparam int M800_V_FP     = 37;
    localparam int M800_V_SYNC   = 6;
    localparam int M800_V_BP     = 23;
    localparam bit M800_HS_POL   = POL_ACTIVE_HIGH;
    localparam bit M800_VS_POL   = POL_ACTIVE_HIGH;

    // Control bits that travel together through the alignment pipeline.
    // All are asserted-high; polarity is only applied at the pins.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
    } syncBits_t;

    function automatic int counterWidth(input int total);
        return (total <= 1) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Shift register that advances only on pixel ticks, used to line the timing
// control bits up with the render pipeline latency. DEPTH = 0 is a wire.
module vga_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pix_en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    if (DEPTH == 0) begin : gPass
        logic unusedCtrl;
        assign unusedCtrl = ^{clock, reset, pix_en_i};
        assign data_o     = data_i;
    end else begin : gShift
        logic [WIDTH-1:0] stage_q [DEPTH];

        // Cleared stages read as blank and sync-inactive.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else if (pix_en_i) begin
                stage_q[0] <= data_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
        end

        assign data_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel/line counters, frame tick, and
// pin-side sync and gated colour aligned to the render pipeline latency.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = M640_H_ACTIVE,
    parameter int H_FP     = M640_H_FP,
    parameter int H_SYNC   = M640_H_SYNC,
    parameter int H_BP     = M640_H_BP,
    parameter int V_ACTIVE = M640_V_ACTIVE,
    parameter int V_FP     = M640_V_FP,
    parameter int V_SYNC   = M640_V_SYNC,
    parameter int V_BP     = M640_V_BP,
    parameter bit HS_POL   = M640_HS_POL,
    parameter bit VS_POL   = M640_VS_POL,
    parameter int COLOR_W  = 4,
    parameter int LAT      = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic pix_en,
    output logic [counterWidth(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0] h_count,
    output logic [counterWidth(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] v_count,
    output logic active,
    output logic frame_tick,
    input  logic [COLOR_W-1:0] red,
    input  logic [COLOR_W-1:0] green,
    input  logic [COLOR_W-1:0] blue,
    output logic [COLOR_W-1:0] red_out,
    output logic [COLOR_W-1:0] green_out,
    output logic [COLOR_W-1:0] blue_out,
    output logic horiz_sync_out,
    output logic vert_sync_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = counterWidth(H_TOTAL);
    localparam int VW      = counterWidth(V_TOTAL);

    // Compares are done at 32 bits so no boundary constant can be truncated.
    localparam logic [31:0] H_LAST     = 32'(H_TOTAL - 1);
    localparam logic [31:0] V_LAST     = 32'(V_TOTAL - 1);
    localparam logic [31:0] H_VIS      = 32'(H_ACTIVE);
    localparam logic [31:0] V_VIS      = 32'(V_ACTIVE);
    localparam logic [31:0] HS_FIRST   = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_LAST    = 32'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [31:0] VS_FIRST   = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_LAST    = 32'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [HW-1:0]      hCount_q, hCount_d;
    logic [VW-1:0]      vCount_q, vCount_d;
    logic [31:0]        hWide, vWide;
    syncBits_t          rawBits, dlyBits;
    logic [COLOR_W-1:0] red_q, green_q, blue_q;
    logic               hsync_q, vsync_q;

    assign hWide = 32'(hCount_q);
    assign vWide = 32'(vCount_q);

    // Raster position: column wraps at end of line and carries into the line.
    always_comb begin
        hCount_d = hCount_q;
        vCount_d = vCount_q;
        if (pix_en) begin
            if (hWide == H_LAST) begin
                hCount_d = '0;
                vCount_d = (vWide == V_LAST) ? '0 : vCount_q + VW'(1);
            end else begin
                hCount_d = hCount_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hCount_q <= '0;
            vCount_q <= '0;
        end else begin
            hCount_q <= hCount_d;
            vCount_q <= vCount_d;
        end
    end

    always_comb begin
        rawBits        = '0;
        rawBits.active = (hWide < H_VIS) && (vWide < V_VIS);
        rawBits.hsync  = (hWide >= HS_FIRST) && (hWide <= HS_LAST);
        rawBits.vsync  = (vWide >= VS_FIRST) && (vWide <= VS_LAST);
    end

    vga_delay_line #(
        .WIDTH ($bits(syncBits_t)),
        .DEPTH (LAT)
    ) uAlign (
        .clock    (clock),
        .reset    (reset),
        .pix_en_i (pix_en),
        .data_i   (rawBits),
        .data_o   (dlyBits)
    );

    // Pin stage: colour is captured together with its delayed control bits,
    // and sync polarity is applied here so the pipeline stays asserted-high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
        end else if (pix_en) begin
            red_q   <= dlyBits.active ? red   : '0;
            green_q <= dlyBits.active ? green : '0;
            blue_q  <= dlyBits.active ? blue  : '0;
            hsync_q <= ~(dlyBits.hsync ^ HS_POL);
            vsync_q <= ~(dlyBits.vsync ^ VS_POL);
        end
    end

    assign h_count        = hCount_q;
    assign v_count        = vCount_q;
    assign active         = rawBits.active;
    assign frame_tick     = pix_en && (hWide == H_LAST) && (vWide == V_LAST);
    assign red_out        = red_q;
    assign green_out      = green_q;
    assign blue_out       = blue_q;
    assign horiz_sync_out = hsync_q;
    assign vert_sync_out  = vsync_q;

endmodule
